// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared encodings for the 4-way round-robin arbiter: mux selects, FSM states,
// and the select-to-grant decode.
package mux4_rr_arbiter_pkg;

    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;
    localparam logic [1:0] SEL_D = 2'b11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Bit 0 of the grant vector is requester A, so a select of 00 lights bit 0.
    function automatic logic [0:3] sel_onehot(input logic [0:1] s);
        logic [0:3] g;
        g    = '0;
        g[s] = 1'b1;
        return g;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Requester/resource side of the arbiter: request and done in, grant, select,
// valid and timeout pulse out.
interface mux4_rr_arbiter_if;
    import mux4_rr_arbiter_pkg::*;

    logic [0:3] req;
    logic       done;
    logic [0:3] gnt;
    logic [0:1] sel;
    logic       valid;
    logic       timeout;

    modport master (
        output req, done,
        input  gnt, sel, valid, timeout
    );

    modport slave (
        input  req, done,
        output gnt, sel, valid, timeout
    );

endinterface

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Combinational round-robin pick: first set request at or after the pointer,
// scanning A,B,C,D circularly.
module rr_pick4
    import mux4_rr_arbiter_pkg::*;
(
    input  logic [0:3] i_req,
    input  logic [1:0] i_ptr,
    output logic       o_found,
    output logic [0:1] o_winner
);

    logic [1:0] w_idx;

    // Scan from the farthest position back to the pointer so the closest hit wins.
    always_comb begin
        o_found  = 1'b0;
        o_winner = SEL_A;
        w_idx    = i_ptr;
        for (int k = 3; k >= 0; k--) begin
            w_idx = i_ptr + 2'(k);
            if (i_req[w_idx]) begin
                o_found  = 1'b1;
                o_winner = w_idx;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for a shared 4:1 muxed resource with done/withdraw/tenure
// release and back-to-back re-arbitration.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | no grant active; sel holds last winner, waiting for any req
//   ST_GRANT | one requester owns the mux; tenure counter running
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CW      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    mux4_rr_arbiter_if.slave bus
);

    state_t        r_state, w_state_nxt;
    logic [1:0]    r_ptr, w_ptr_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [0:3]    r_gnt, w_gnt_nxt;
    logic [0:1]    r_sel, w_sel_nxt;
    logic          r_valid, w_valid_nxt;
    logic          r_timeout, w_timeout_nxt;

    logic [1:0]    w_arb_ptr;
    logic          w_found;
    logic [0:1]    w_winner;
    logic          w_rel_done, w_rel_drop, w_rel_to, w_release, w_start;

    assign w_rel_done = bus.done;
    assign w_rel_drop = ~bus.req[r_sel];
    assign w_rel_to   = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT - 1));
    assign w_release  = (r_state == ST_GRANT) && (w_rel_done || w_rel_drop || w_rel_to);

    // On release the pointer steps past the current owner in the same edge, so
    // the owner only wins again when nobody else is asking.
    assign w_arb_ptr  = (r_state == ST_GRANT) ? 2'(r_sel + 2'd1) : r_ptr;
    assign w_start    = w_found && ((r_state == ST_IDLE) || w_release);

    rr_pick4 u_pick (
        .i_req    (bus.req),
        .i_ptr    (w_arb_ptr),
        .o_found  (w_found),
        .o_winner (w_winner)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_ptr     <= SEL_A;
            r_cnt     <= '0;
            r_gnt     <= '0;
            r_sel     <= SEL_A;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_gnt     <= w_gnt_nxt;
            r_sel     <= w_sel_nxt;
            r_valid   <= w_valid_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_found) w_state_nxt = ST_GRANT;
            ST_GRANT: if (w_release && !w_found) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_ptr_nxt     = r_ptr;
        w_cnt_nxt     = r_cnt;
        w_gnt_nxt     = r_gnt;
        w_sel_nxt     = r_sel;
        w_valid_nxt   = r_valid;
        w_timeout_nxt = w_release && w_rel_to && !w_rel_done && !w_rel_drop;

        if (w_release)
            w_ptr_nxt = 2'(r_sel + 2'd1);

        if (w_start) begin
            w_gnt_nxt   = sel_onehot(w_winner);
            w_sel_nxt   = w_winner;
            w_valid_nxt = 1'b1;
            w_cnt_nxt   = '0;
        end else if (w_release) begin
            w_gnt_nxt   = '0;
            w_valid_nxt = 1'b0;
            w_cnt_nxt   = '0;
        end else if (r_state == ST_GRANT) begin
            w_cnt_nxt   = r_cnt + 1'b1;
        end
    end

    assign bus.gnt     = r_gnt;
    assign bus.sel     = r_sel;
    assign bus.valid   = r_valid;
    assign bus.timeout = r_timeout;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter with a 4-cycle tenure limit; expected
// outputs are hand-computed per step.
module tb_mux4_rr_arbiter;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    mux4_rr_arbiter_if bus();

    mux4_rr_arbiter #(.TIMEOUT(4), .CW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [0:3] eg, input logic [0:1] es,
                       input logic ev, input logic et);
        logic [7:0] obs;
        logic [7:0] exp;
        obs = {bus.gnt, bus.sel, bus.valid, bus.timeout};
        exp = {eg, es, ev, et};
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed gnt=%b sel=%b valid=%b timeout=%b, expected gnt=%b sel=%b valid=%b timeout=%b",
                   tag, bus.gnt, bus.sel, bus.valid, bus.timeout, eg, es, ev, et);
        end
    endtask

    logic [0:3] rr_gnt [5];
    logic [0:1] rr_sel [5];

    initial begin
        n_cmp    = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.req  = 4'b0000;
        bus.done = 1'b0;
        rr_gnt   = '{4'b0100, 4'b0010, 4'b0001, 4'b1000, 4'b0100};
        rr_sel   = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01};

        #3;
        chk("reset_async", 4'b0000, 2'b00, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        chk("reset_hold", 4'b0000, 2'b00, 1'b0, 1'b0);

        // 1: sole requester A, done, regrant, then pointer moved to B
        bus.req = 4'b1000;
        tick();
        chk("t1_grant_a", 4'b1000, 2'b00, 1'b1, 1'b0);
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        chk("t1_regrant_a", 4'b1000, 2'b00, 1'b1, 1'b0);
        bus.req = 4'b0000;
        tick();
        chk("t1_idle", 4'b0000, 2'b00, 1'b0, 1'b0);
        bus.req = 4'b1111;
        tick();
        chk("t1_ptr_b", 4'b0100, 2'b01, 1'b1, 1'b0);

        // 2: all request, done on third granted cycle, no bubbles
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_hold1", rr_gnt[i], rr_sel[i], 1'b1, 1'b0);
            tick();
            bus.done = 1'b1;
            chk("t2_hold2", rr_gnt[i], rr_sel[i], 1'b1, 1'b0);
            tick();
            bus.done = 1'b0;
            chk("t2_next", rr_gnt[i+1], rr_sel[i+1], 1'b1, 1'b0);
        end

        // 3: tenure expiry on B, sole requester then with C pending
        bus.req = 4'b0100;
        tick();
        chk("t3_cnt1", 4'b0100, 2'b01, 1'b1, 1'b0);
        tick();
        tick();
        chk("t3_cnt3", 4'b0100, 2'b01, 1'b1, 1'b0);
        tick();
        chk("t3_to_regrant_b", 4'b0100, 2'b01, 1'b1, 1'b1);
        bus.req = 4'b0110;
        tick();
        chk("t3_to_pulse_end", 4'b0100, 2'b01, 1'b1, 1'b0);
        tick();
        tick();
        chk("t3_cnt3_b", 4'b0100, 2'b01, 1'b1, 1'b0);
        tick();
        chk("t3_to_grant_c", 4'b0010, 2'b10, 1'b1, 1'b1);

        // 4: C withdraws, D then A
        bus.req = 4'b1001;
        tick();
        chk("t4_drop_to_d", 4'b0001, 2'b11, 1'b1, 1'b0);
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        chk("t4_d_to_a", 4'b1000, 2'b00, 1'b1, 1'b0);

        // 5: done coincides with expiry; then done while idle
        tick();
        tick();
        tick();
        chk("t5_a_cnt3", 4'b1000, 2'b00, 1'b1, 1'b0);
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        chk("t5_done_and_to", 4'b0001, 2'b11, 1'b1, 1'b0);
        bus.req = 4'b0000;
        tick();
        chk("t5_idle_sel_held", 4'b0000, 2'b11, 1'b0, 1'b0);
        bus.done = 1'b1;
        tick();
        chk("t5_idle_done1", 4'b0000, 2'b11, 1'b0, 1'b0);
        tick();
        bus.done = 1'b0;
        chk("t5_idle_done2", 4'b0000, 2'b11, 1'b0, 1'b0);

        // 6: async reset mid-grant on D, pointer back at A
        bus.req = 4'b0001;
        tick();
        chk("t6_grant_d", 4'b0001, 2'b11, 1'b1, 1'b0);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_rst", 4'b0000, 2'b00, 1'b0, 1'b0);
        bus.req = 4'b0011;
        tick();
        chk("t6_rst_held", 4'b0000, 2'b00, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        chk("t6_grant_c", 4'b0010, 2'b10, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
